// File: rtl/conv_filter_pkg.sv
// rtl/conv_filter_pkg.sv - shared widths, coefficient bank type and kernel helpers for the window filter
// Contents:
//   CF_* localparams    default filter geometry
//   prod_w/tree_depth/sum_w  datapath width helpers
//   coef_bank_t         packed bank of N signed coefficients
//   identity_kernel()   pass-through kernel (centre tap = 1.0 after normalisation)
package conv_filter_pkg;

  localparam int CF_PIX_DATA_W  = 12;
  localparam int CF_WINDOW_SIZE = 3;
  localparam int CF_N           = CF_WINDOW_SIZE * CF_WINDOW_SIZE;
  localparam int CF_COEF_W      = 8;
  localparam int CF_NORM_SHIFT  = 4;

  // Product of a signed coefficient and a zero-extended unsigned pixel.
  function automatic int prod_w(int pix_w, int coef_w);
    return pix_w + 1 + coef_w;
  endfunction

  function automatic int tree_depth(int n);
    return $clog2(n);
  endfunction

  // One growth bit per adder level keeps the tree overflow-free.
  function automatic int sum_w(int pix_w, int coef_w, int n);
    return prod_w(pix_w, coef_w) + tree_depth(n);
  endfunction

  typedef logic [CF_N-1:0][CF_COEF_W-1:0] coef_bank_t;

  function automatic coef_bank_t identity_kernel(int n, int norm_shift);
    coef_bank_t bank;
    bank = '0;
    for (int k = 0; k < n; k++) begin
      if (k == n / 2) bank[k] = CF_COEF_W'(1 << norm_shift);
    end
    return bank;
  endfunction

endpackage

// File: rtl/pipelined_adder_tree.sv
// rtl/pipelined_adder_tree.sv - registered binary adder tree, one register per level, valid carried alongside
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset (clears valid only)
//   valid_i        input valid
//   data_i         N signed operands of IN_W bits
//   valid_o        output valid, $clog2(N) cycles after valid_i
//   data_o         signed sum, IN_W+$clog2(N) bits
module pipelined_adder_tree #(
  parameter int N    = 9,
  parameter int IN_W = 21
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         valid_i,
  input  logic [N-1:0][IN_W-1:0]       data_i,
  output logic                         valid_o,
  output logic [IN_W+$clog2(N)-1:0]    data_o
);

  localparam int DEPTH = $clog2(N);

  // Number of operands entering level l.
  function automatic int level_cnt(int l);
    int c;
    c = N;
    for (int i = 0; i < l; i++) c = (c + 1) / 2;
    return c;
  endfunction

  if (DEPTH == 0) begin : g_pass
    assign data_o  = data_i[0];
    assign valid_o = valid_i;
  end else begin : g_tree
    for (genvar l = 0; l < DEPTH; l++) begin : g_lvl
      localparam int CIN  = level_cnt(l);
      localparam int COUT = level_cnt(l + 1);
      localparam int WI   = IN_W + l;
      localparam int WO   = WI + 1;

      logic [CIN-1:0][WI-1:0]  in_w;
      logic                    in_vld;
      logic [COUT-1:0][WO-1:0] sum_q;
      logic                    vld_q;

      if (l == 0) begin : g_src
        assign in_w   = data_i;
        assign in_vld = valid_i;
      end else begin : g_src
        assign in_w   = g_lvl[l-1].sum_q;
        assign in_vld = g_lvl[l-1].vld_q;
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) vld_q <= 1'b0;
        else       vld_q <= in_vld;
        for (int k = 0; k < COUT; k++) begin
          // An odd leftover operand is forwarded, sign-extended, to the next level.
          if (2 * k + 1 < CIN)
            sum_q[k] <= {in_w[2*k][WI-1], in_w[2*k]}
                      + {in_w[(2*k+1 < CIN) ? 2*k+1 : 2*k][WI-1],
                         in_w[(2*k+1 < CIN) ? 2*k+1 : 2*k]};
          else
            sum_q[k] <= {in_w[2*k][WI-1], in_w[2*k]};
        end
      end
    end

    assign data_o  = g_lvl[DEPTH-1].sum_q[0];
    assign valid_o = g_lvl[DEPTH-1].vld_q;
  end

endmodule

// File: rtl/conv_window_filter.sv
// rtl/conv_window_filter.sv - pipelined WINDOW_SIZE x WINDOW_SIZE signed convolution with frame-committed kernel
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   vd_stb              frame strobe, copies shadow kernel to active kernel
//   win_valid_i         one pulse per window
//   win_data_i          N unsigned pixels, k = row*WINDOW_SIZE + col
//   coef_wr_en_i        shadow coefficient write
//   coef_addr_i         tap index (>= N ignored)
//   coef_data_i         signed coefficient
//   pix_valid_o         filtered pixel valid, 2+$clog2(N) cycles after win_valid_i
//   pix_data_o          filtered pixel, held between valid pulses
module conv_window_filter
  import conv_filter_pkg::*;
#(
  parameter int PIX_DATA_W        = CF_PIX_DATA_W,
  parameter int WINDOW_SIZE       = CF_WINDOW_SIZE,
  parameter int WINDOW_PIX_AMOUNT = WINDOW_SIZE ** 2,
  parameter int COEF_W            = CF_COEF_W,
  parameter int NORM_SHIFT        = CF_NORM_SHIFT
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          vd_stb,
  input  logic                                          win_valid_i,
  input  logic [WINDOW_PIX_AMOUNT-1:0][PIX_DATA_W-1:0]  win_data_i,
  input  logic                                          coef_wr_en_i,
  input  logic [$clog2(WINDOW_PIX_AMOUNT)-1:0]          coef_addr_i,
  input  logic [COEF_W-1:0]                             coef_data_i,
  output logic                                          pix_valid_o,
  output logic [PIX_DATA_W-1:0]                         pix_data_o
);

  localparam int N      = WINDOW_PIX_AMOUNT;
  localparam int PROD_W = prod_w(PIX_DATA_W, COEF_W);
  localparam int SUM_W  = sum_w(PIX_DATA_W, COEF_W, N);
  localparam int ROUND  = (NORM_SHIFT > 0) ? (1 << (NORM_SHIFT - 1)) : 0;
  localparam coef_bank_t IDENT = identity_kernel(N, NORM_SHIFT);

  coef_bank_t                 shadow_q, active_q;
  logic [N-1:0][PROD_W-1:0]   prod_q;
  logic                       prod_vld_q;
  logic [SUM_W-1:0]           tree_sum;
  logic                       tree_vld;
  logic signed [SUM_W:0]      rnd_sum, shifted;
  logic [PIX_DATA_W-1:0]      pix_data_d;
  logic [PIX_DATA_W-1:0]      pix_data_q;
  logic                       pix_valid_q;

  // Both assignments read the pre-edge shadow, so a write coinciding with
  // vd_stb reaches the active bank only at the following strobe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q <= IDENT;
      active_q <= IDENT;
    end else begin
      if (vd_stb) active_q <= shadow_q;
      if (coef_wr_en_i && (int'(coef_addr_i) < N)) shadow_q[coef_addr_i] <= coef_data_i;
    end
  end

  // S1: products are formed with the kernel active at sampling time, so
  // windows already in flight are unaffected by a later commit.
  always_ff @(posedge clk_i) begin
    if (rst_i) prod_vld_q <= 1'b0;
    else       prod_vld_q <= win_valid_i;
    for (int k = 0; k < N; k++) begin
      prod_q[k] <= PROD_W'($signed(active_q[k])) * PROD_W'($signed({1'b0, win_data_i[k]}));
    end
  end

  pipelined_adder_tree #(
    .N    (N),
    .IN_W (PROD_W)
  ) u_tree (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (prod_vld_q),
    .data_i  (prod_q),
    .valid_o (tree_vld),
    .data_o  (tree_sum)
  );

  // Round half up, arithmetic shift, then clamp to the unsigned pixel range.
  always_comb begin
    rnd_sum    = {tree_sum[SUM_W-1], tree_sum} + (SUM_W + 1)'(ROUND);
    shifted    = rnd_sum >>> NORM_SHIFT;
    pix_data_d = shifted[PIX_DATA_W-1:0];
    if (shifted[SUM_W])                       pix_data_d = '0;
    else if (|shifted[SUM_W-1:PIX_DATA_W])    pix_data_d = '1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
    end else begin
      pix_valid_q <= tree_vld;
      if (tree_vld) pix_data_q <= pix_data_d;
    end
  end

  assign pix_valid_o = pix_valid_q;
  assign pix_data_o  = pix_data_q;

endmodule

// File: tb/tb_conv_window_filter.sv
// tb/tb_conv_window_filter.sv - self-checking bench for conv_window_filter against a behavioural model
module tb_conv_window_filter;

  localparam int N    = 9;
  localparam int PW   = 12;
  localparam int CW   = 8;
  localparam int L    = 6;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, vd, wv, wr;
  logic [N-1:0][PW-1:0] wdata;
  logic [3:0]           addr;
  logic [CW-1:0]        cdata;
  logic                 pv;
  logic [PW-1:0]        pd;

  conv_window_filter dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .vd_stb       (vd),
    .win_valid_i  (wv),
    .win_data_i   (wdata),
    .coef_wr_en_i (wr),
    .coef_addr_i  (addr),
    .coef_data_i  (cdata),
    .pix_valid_o  (pv),
    .pix_data_o   (pd)
  );

  int n_checks = 0;
  int n_errs   = 0;
  int m_shadow[N];
  int m_active[N];
  bit exp_v[MAXC];
  int exp_d[MAXC];
  bit rst_at[MAXC];
  int held    = 0;
  int edge_n  = 0;
  int out_cnt = 0;

  int gauss[N] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
  int satk[N]  = '{-1, -1, -1, -1, 127, -1, -1, -1, -1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int filt(input logic [N-1:0][PW-1:0] w);
    int s;
    s = 0;
    for (int k = 0; k < N; k++) s += m_active[k] * int'(w[k]);
    s = (s + 8) >>> 4;
    if (s < 0) return 0;
    if (s > 4095) return 4095;
    return s;
  endfunction

  // One clock: model sees the same inputs as the DUT edge, then outputs are compared mid-cycle.
  task automatic tick();
    int e;
    @(posedge clk);
    edge_n++;
    e = edge_n;
    if (rst) begin
      for (int i = 0; i < L; i++) exp_v[e+i] = 1'b0;
      rst_at[e] = 1'b1;
      for (int k = 0; k < N; k++) begin
        m_shadow[k] = (k == N / 2) ? 16 : 0;
        m_active[k] = (k == N / 2) ? 16 : 0;
      end
    end else begin
      if (wv) begin
        exp_v[e+L-1] = 1'b1;
        exp_d[e+L-1] = filt(wdata);
      end
      if (vd) m_active = m_shadow;
      if (wr && addr < N) m_shadow[addr] = int'($signed(cdata));
    end
    @(negedge clk);
    if (rst_at[e]) held = 0;
    else if (exp_v[e]) held = exp_d[e];
    check("pix_valid", 32'(pv), 32'(exp_v[e]));
    check("pix_data", 32'(pd), held);
    if (pv) out_cnt++;
  endtask

  task automatic idle(input int n);
    wv = 0; wr = 0; vd = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic fill(input int v);
    for (int k = 0; k < N; k++) wdata[k] = 12'(v);
  endtask

  task automatic send();
    wv = 1; tick(); wv = 0;
  endtask

  task automatic write_coef(input int a, input int d, input bit v);
    wr = 1; addr = 4'(a); cdata = 8'(d); vd = v;
    tick();
    wr = 0; vd = 0;
  endtask

  task automatic load_kernel(input int kern[N], input bit commit_last);
    for (int k = 0; k < N; k++) write_coef(k, kern[k], commit_last && (k == N - 1));
  endtask

  task automatic commit();
    vd = 1; tick(); vd = 0;
  endtask

  initial begin
    int c0;
    rst = 1; vd = 0; wv = 0; wr = 0; addr = '0; cdata = '0; wdata = '0;
    repeat (3) tick();
    rst = 0;
    idle(2);

    // identity kernel after reset
    c0 = out_cnt;
    fill(0); wdata[4] = 12'd1234;
    send(); idle(8);
    check("ident_cnt", out_cnt - c0, 1);
    check("ident_data", 32'(pd), 1234);

    // gaussian stream with a 3-cycle bubble
    load_kernel(gauss, 1'b0); commit();
    c0 = out_cnt;
    fill(100);
    repeat (10) send();
    idle(3);
    repeat (10) send();
    idle(8);
    check("gauss_cnt", out_cnt - c0, 20);
    check("gauss_data", 32'(pd), 100);

    // rounding
    fill(0); wdata[0] = 12'd8; send(); idle(7);
    check("round_up", 32'(pd), 1);
    fill(0); wdata[0] = 12'd7; send(); idle(7);
    check("round_down", 32'(pd), 0);

    // saturation
    load_kernel(satk, 1'b0); commit();
    fill(4095); wdata[4] = 12'd0; send(); idle(7);
    check("sat_low", 32'(pd), 0);
    fill(0); wdata[4] = 12'd4095; send(); idle(7);
    check("sat_high", 32'(pd), 4095);

    // commit in the same cycle as the last write: tap 8 keeps old -1
    load_kernel(gauss, 1'b1);
    fill(100); send(); idle(7);
    check("commit_same_cycle", 32'(pd), 88);
    write_coef(9, 50, 1'b0);
    send(); idle(7);
    check("no_commit_yet", 32'(pd), 88);
    commit();
    send(); idle(7);
    check("addr9_ignored", 32'(pd), 100);

    // window in flight while the kernel changes
    load_kernel(satk, 1'b0);
    fill(100); send(); commit(); idle(7);
    check("inflight_old_kernel", 32'(pd), 100);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      wv = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) wdata[k] = 12'($urandom);
      wr    = ($urandom_range(0, 3) == 0);
      addr  = 4'($urandom_range(0, 15));
      cdata = 8'($urandom);
      vd    = ($urandom_range(0, 19) == 0);
      tick();
    end
    idle(8);

    // reset with three windows in flight
    c0 = out_cnt;
    fill(500); wv = 1;
    repeat (3) tick();
    wv = 0; rst = 1; tick(); rst = 0;
    idle(10);
    check("rst_drop_cnt", out_cnt - c0, 0);
    check("rst_data", 32'(pd), 0);
    fill(0); wdata[4] = 12'd777; send(); idle(7);
    check("rst_identity", 32'(pd), 777);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
